// File: rtl/lock_access_sequencer.sv
// Keypad front-end for the 4-digit lock core: synchronizes and strobes key codes, sequences entry
// sessions, counts failures, enforces lockout and auto-cancels idle entries. Define LOCK_ALARM_EN for the lockout alarm.

module lock_access_sequencer #(
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int TIMER_W        = 16,
  parameter int ALARM_HALF     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_raw,
  input  logic       core_unlocked,
  input  logic       core_wrong,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       core_cancel,
  output logic       lockout,
  output logic [2:0] fail_count,
  output logic       busy,
  output logic       alarm
);

  if (MAX_FAIL < 1 || MAX_FAIL > 7 || ALARM_HALF < 1 || TIMEOUT_CYCLES < 1 || LOCKOUT_CYCLES < 1 ||
      longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMER_W) ||
      longint'(LOCKOUT_CYCLES) >= (longint'(1) << TIMER_W)) begin : g_param_check
    $error("lock_access_sequencer: parameter out of range");
  end

  localparam logic [3:0]         KEY_NONE     = 4'hF;
  localparam logic [3:0]         KEY_CANCEL   = 4'hD;
  localparam logic [2:0]         FAIL_LIMIT   = 3'(MAX_FAIL);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;

  typedef enum logic [1:0] {
    ST_READY,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         fail_d;
  logic [2:0]         fail_inc;
  logic [3:0]         sync_meta, sync_key, sync_prev;
  logic               press;
  logic               cancel_key;
  logic               forward;
  logic               cancel_req;

  // Two-flop synchronizer plus one history stage for edge detection on the code bus.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= KEY_NONE;
      sync_key  <= KEY_NONE;
      sync_prev <= KEY_NONE;
    end else begin
      sync_meta <= key_raw;
      sync_key  <= sync_meta;
      sync_prev <= sync_key;
    end
  end

  assign press      = (sync_key != KEY_NONE) && (sync_prev == KEY_NONE);
  assign cancel_key = (sync_key == KEY_CANCEL);
  assign forward    = press && (state_q != ST_LOCKOUT);
  assign fail_inc   = (fail_count >= FAIL_LIMIT) ? FAIL_LIMIT : fail_count + 3'd1;

  // NOTE: each signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fail_d     = fail_count;
    cancel_req = 1'b0;
    case (state_q)
      ST_READY: begin
        if (press) begin
          if (cancel_key) begin
            cancel_req = 1'b1;
          end else begin
            state_d = ST_ENTRY;
            timer_d = '0;
          end
        end
      end
      ST_ENTRY: begin
        // Priority: wrong beats unlocked, and any key press beats the inactivity timeout.
        if (core_wrong) begin
          cancel_req = 1'b1;
          fail_d     = fail_inc;
          if (fail_inc == FAIL_LIMIT) begin
            state_d = ST_LOCKOUT;
            timer_d = '0;
          end else begin
            state_d = ST_READY;
          end
        end else if (core_unlocked) begin
          fail_d  = '0;
          state_d = ST_OPEN;
        end else if (press && cancel_key) begin
          cancel_req = 1'b1;
          state_d    = ST_READY;
        end else if (press) begin
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          cancel_req = 1'b1;
          state_d    = ST_READY;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OPEN: begin
        if (!core_unlocked) begin
          state_d = ST_READY;
        end
        if (press && cancel_key) begin
          cancel_req = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = ST_READY;
          fail_d  = '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      timer_q     <= '0;
      fail_count  <= '0;
      key_valid   <= 1'b0;
      key_code    <= KEY_NONE;
      core_cancel <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      fail_count  <= fail_d;
      key_valid   <= forward;
      if (forward) begin
        key_code <= sync_key;
      end
      // A cancel request right after a cancel pulse is redundant: the core is already idle.
      core_cancel <= cancel_req && !core_cancel;
      lockout     <= (state_d == ST_LOCKOUT);
    end
  end

  assign busy = (state_q == ST_ENTRY) || (state_q == ST_OPEN);

`ifdef LOCK_ALARM_EN
  localparam int ALARM_CW = (ALARM_HALF > 1) ? $clog2(ALARM_HALF) : 1;
  localparam logic [ALARM_CW-1:0] ALARM_LAST = ALARM_CW'(ALARM_HALF - 1);

  logic [ALARM_CW-1:0] alarm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (state_d != ST_LOCKOUT) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (state_q != ST_LOCKOUT) begin
      alarm     <= 1'b1;
      alarm_cnt <= '0;
    end else if (alarm_cnt == ALARM_LAST) begin
      alarm     <= ~alarm;
      alarm_cnt <= '0;
    end else begin
      alarm_cnt <= alarm_cnt + 1'b1;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_access_sequencer.sv
// Self-checking bench for lock_access_sequencer: randomized keypad sessions checked against
// expectations derived from cycle arithmetic and a saturating failure-count model.

module tb_lock_access_sequencer;

  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYC = 100;
  localparam int TO_CYC   = 50;
  localparam int HALF     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic       core_unlocked = 1'b0;
  logic       core_wrong = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       core_cancel;
  logic       lockout;
  logic [2:0] fail_count;
  logic       busy;
  logic       alarm;

  lock_access_sequencer #(
    .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCK_CYC), .TIMEOUT_CYCLES(TO_CYC),
    .TIMER_W(16), .ALARM_HALF(HALF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .core_unlocked(core_unlocked),
    .core_wrong(core_wrong), .key_valid(key_valid), .key_code(key_code),
    .core_cancel(core_cancel), .lockout(lockout), .fail_count(fail_count),
    .busy(busy), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic [3:0] code; } strobe_t;
  strobe_t kv_log[$];
  int      cc_log[$];
  logic    alarm_at[int];

  always @(negedge clk) begin
    alarm_at[cyc] = alarm;
    if (rst_n && key_valid)   kv_log.push_back('{at: cyc, code: key_code});
    if (rst_n && core_cancel) cc_log.push_back(cyc);
  end

  int total = 0;
  int bad = 0;
  int model_fail = 0;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [3:0] rand_digit();
    return 4'($urandom_range(1, 9));
  endfunction

  task automatic press(input logic [3:0] code, input int hold, output int at);
    at = cyc;
    key_raw = code;
    step(hold);
    key_raw = 4'hF;
    step(3);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; key_raw = 4'hF; core_wrong = 1'b0; core_unlocked = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    model_fail = 0;
  endtask

  // One entry session ended by a one-cycle core_wrong; w is the cycle it was driven.
  task automatic fail_session(output int w);
    int at;
    press(rand_digit(), $urandom_range(1, 4), at);
    step($urandom_range(0, 30));
    w = cyc;
    core_wrong = 1'b1;
    step(1);
    core_wrong = 1'b0;
    step(2);
    model_fail = (model_fail + 1 > MAX_FAIL) ? MAX_FAIL : model_fail + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    total++; if (key_valid !== 1'b0)   begin bad++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
    total++; if (key_code !== 4'hF)    begin bad++; $display("FAIL reset_key_code got=%h want=f", key_code); end
    total++; if (core_cancel !== 1'b0) begin bad++; $display("FAIL reset_cancel got=%b want=0", core_cancel); end
    total++; if (lockout !== 1'b0)     begin bad++; $display("FAIL reset_lockout got=%b want=0", lockout); end
    total++; if (fail_count !== 3'd0)  begin bad++; $display("FAIL reset_fail got=%0d want=0", fail_count); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (alarm !== 1'b0)       begin bad++; $display("FAIL reset_alarm got=%b want=0", alarm); end
    rst_n = 1'b1;
    step(3);
    total++; if (busy !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL reset_release busy=%b kv=%b want=0,0", busy, key_valid); end
  endtask

  task automatic test_single_press();
    logic [3:0] d;
    int at, s, kb, cb;
    apply_reset();
    d = rand_digit(); kb = kv_log.size(); cb = cc_log.size();
    at = cyc; key_raw = d; step(20); key_raw = 4'hF; step(3);
    s = at + 3;
    total++;
    if (kv_log.size() - kb !== 1) begin bad++; $display("FAIL hold_strobe_count got=%0d want=1", kv_log.size() - kb); end
    else begin
      total++;
      if (kv_log[kb].at !== s || kv_log[kb].code !== d) begin
        bad++; $display("FAIL hold_strobe got=@%0d/%h want=@%0d/%h", kv_log[kb].at, kv_log[kb].code, s, d);
      end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy); end
    total++; if (cc_log.size() !== cb) begin bad++; $display("FAIL hold_no_cancel got=%0d want=%0d", cc_log.size(), cb); end
    wait_to(s + TO_CYC + 2);
    total++;
    if (cc_log.size() - cb !== 1) begin bad++; $display("FAIL timeout_count got=%0d want=1", cc_log.size() - cb); end
    else begin
      total++; if (cc_log[cb] !== s + TO_CYC) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", cc_log[cb], s + TO_CYC); end
    end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL timeout_busy got=%b want=0", busy); end
    total++; if (fail_count !== 3'd0) begin bad++; $display("FAIL timeout_fail got=%0d want=0", fail_count); end
    total++; if (key_code !== d)      begin bad++; $display("FAIL key_code_hold got=%h want=%h", key_code, d); end
  endtask

  task automatic test_lockout();
    int w, cb, kb, at, lock_start;
    logic [3:0] code;
    logic exp;
    apply_reset();
    for (int i = 1; i <= MAX_FAIL; i++) begin
      cb = cc_log.size();
      fail_session(w);
      total++;
      if (cc_log.size() - cb !== 1 || cc_log[cb] !== w + 1) begin
        bad++; $display("FAIL wrong_cancel_%0d count=%0d want=1 at=%0d", i, cc_log.size() - cb, w + 1);
      end
      total++; if (fail_count !== 3'(model_fail)) begin bad++; $display("FAIL fail_count_%0d got=%0d want=%0d", i, fail_count, model_fail); end
      total++; if (lockout !== (i == MAX_FAIL)) begin bad++; $display("FAIL lockout_%0d got=%b want=%b", i, lockout, i == MAX_FAIL); end
    end
    lock_start = w + 1;
    kb = kv_log.size(); cb = cc_log.size();
    while (cyc < lock_start + 75) begin
      case ($urandom_range(0, 2))
        0:       code = 4'hD;
        1:       code = 4'hE;
        default: code = rand_digit();
      endcase
      press(code, $urandom_range(1, 5), at);
      step($urandom_range(0, 5));
    end
    wait_to(lock_start + LOCK_CYC - 1);
    total++; if (lockout !== 1'b1) begin bad++; $display("FAIL lockout_last_cycle got=%b want=1", lockout); end
    step(1);
    total++; if (lockout !== 1'b0)    begin bad++; $display("FAIL lockout_exit got=%b want=0", lockout); end
    total++; if (fail_count !== 3'd0) begin bad++; $display("FAIL lockout_exit_fail got=%0d want=0", fail_count); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL lockout_exit_busy got=%b want=0", busy); end
    total++; if (kv_log.size() !== kb) begin bad++; $display("FAIL lockout_strobes got=%0d want=0", kv_log.size() - kb); end
    total++; if (cc_log.size() !== cb) begin bad++; $display("FAIL lockout_cancels got=%0d want=0", cc_log.size() - cb); end
    model_fail = 0;
    for (int k = 0; k <= LOCK_CYC; k++) begin
`ifdef LOCK_ALARM_EN
      exp = (k < LOCK_CYC) && ((k / HALF) % 2 == 0);
`else
      exp = 1'b0;
`endif
      total++;
      if (alarm_at[lock_start + k] !== exp) begin
        bad++; $display("FAIL alarm_k%0d got=%b want=%b", k, alarm_at[lock_start + k], exp);
      end
    end
    kb = kv_log.size();
    code = rand_digit();
    press(code, 2, at);
    total++;
    if (kv_log.size() - kb !== 1 || kv_log[kb].code !== code || kv_log[kb].at !== at + 3) begin
      bad++; $display("FAIL post_lockout_strobe count=%0d want=1 code=%h", kv_log.size() - kb, code);
    end
  endtask

  task automatic test_open();
    int w, at, kb, cb;
    logic [3:0] codes[5];
    int ats[5];
    apply_reset();
    fail_session(w);
    fail_session(w);
    total++; if (fail_count !== 3'(model_fail)) begin bad++; $display("FAIL open_pre_fail got=%0d want=%0d", fail_count, model_fail); end
    press(rand_digit(), $urandom_range(1, 4), at);
    step($urandom_range(0, 10));
    cb = cc_log.size();
    core_unlocked = 1'b1;
    step(2);
    model_fail = 0;
    total++; if (fail_count !== 3'd0) begin bad++; $display("FAIL open_fail_clear got=%0d want=0", fail_count); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL open_busy got=%b want=1", busy); end
    total++; if (lockout !== 1'b0)    begin bad++; $display("FAIL open_lockout got=%b want=0", lockout); end
    kb = kv_log.size();
    codes[0] = 4'hE;
    for (int j = 1; j < 5; j++) codes[j] = rand_digit();
    for (int j = 0; j < 5; j++) begin
      press(codes[j], $urandom_range(1, 4), ats[j]);
      step($urandom_range(0, 3));
    end
    total++;
    if (kv_log.size() - kb !== 5) begin bad++; $display("FAIL open_strobe_count got=%0d want=5", kv_log.size() - kb); end
    else begin
      for (int j = 0; j < 5; j++) begin
        total++;
        if (kv_log[kb + j].at !== ats[j] + 3 || kv_log[kb + j].code !== codes[j]) begin
          bad++; $display("FAIL open_strobe_%0d got=@%0d/%h want=@%0d/%h", j, kv_log[kb + j].at, kv_log[kb + j].code, ats[j] + 3, codes[j]);
        end
      end
    end
    step(TO_CYC + 10);
    total++; if (cc_log.size() !== cb) begin bad++; $display("FAIL open_no_timeout got=%0d want=0", cc_log.size() - cb); end
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL open_still_busy got=%b want=1", busy); end
    kb = kv_log.size();
    press(4'hD, 2, at);
    total++;
    if (kv_log.size() - kb !== 1 || kv_log[kb].code !== 4'hD || cc_log.size() - cb !== 1 || cc_log[cb] !== at + 3) begin
      bad++; $display("FAIL open_cancel_key strobes=%0d cancels=%0d want=1,1 at=%0d", kv_log.size() - kb, cc_log.size() - cb, at + 3);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL open_after_d_busy got=%b want=1", busy); end
    core_unlocked = 1'b0;
    step(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL open_close_busy got=%b want=0", busy); end
  endtask

  task automatic test_wrong_unlock_reset();
    int at, w, cb, kb;
    apply_reset();
    press(rand_digit(), $urandom_range(1, 4), at);
    step($urandom_range(0, 20));
    cb = cc_log.size();
    w = cyc;
    core_wrong = 1'b1; core_unlocked = 1'b1;
    step(1);
    core_wrong = 1'b0; core_unlocked = 1'b0;
    step(2);
    model_fail = 1;
    total++; if (fail_count !== 3'd1) begin bad++; $display("FAIL both_fail got=%0d want=1", fail_count); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL both_not_open got=%b want=0", busy); end
    total++;
    if (cc_log.size() - cb !== 1 || cc_log[cb] !== w + 1) begin
      bad++; $display("FAIL both_cancel count=%0d want=1 at=%0d", cc_log.size() - cb, w + 1);
    end
    fail_session(w);
    fail_session(w);
    total++; if (lockout !== 1'b1) begin bad++; $display("FAIL pre_reset_lockout got=%b want=1", lockout); end
    step($urandom_range(5, 40));
    rst_n = 1'b0;
    #1;
    total++; if (lockout !== 1'b0)     begin bad++; $display("FAIL async_lockout got=%b want=0", lockout); end
    total++; if (fail_count !== 3'd0)  begin bad++; $display("FAIL async_fail got=%0d want=0", fail_count); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
    total++; if (key_code !== 4'hF)    begin bad++; $display("FAIL async_key_code got=%h want=f", key_code); end
    total++; if (key_valid !== 1'b0)   begin bad++; $display("FAIL async_key_valid got=%b want=0", key_valid); end
    total++; if (core_cancel !== 1'b0) begin bad++; $display("FAIL async_cancel got=%b want=0", core_cancel); end
    total++; if (alarm !== 1'b0)       begin bad++; $display("FAIL async_alarm got=%b want=0", alarm); end
    step(2);
    rst_n = 1'b1;
    step(2);
    model_fail = 0;
    kb = kv_log.size();
    press(rand_digit(), 2, at);
    total++; if (kv_log.size() - kb !== 1) begin bad++; $display("FAIL post_reset_strobe got=%0d want=1", kv_log.size() - kb); end
    total++; if (busy !== 1'b1)            begin bad++; $display("FAIL post_reset_busy got=%b want=1", busy); end
  endtask

  task automatic test_back_to_back();
    int at, at2, s1, kb, cb, p;
    logic [3:0] d2;
    apply_reset();
    // Cancel key while idle: forwarded with a cancel pulse in the same cycle.
    kb = kv_log.size(); cb = cc_log.size();
    press(4'hD, $urandom_range(1, 6), at);
    total++;
    if (kv_log.size() - kb !== 1 || kv_log[kb].code !== 4'hD || cc_log.size() - cb !== 1 || cc_log[cb] !== at + 3) begin
      bad++; $display("FAIL ready_cancel strobes=%0d cancels=%0d want=1,1 at=%0d", kv_log.size() - kb, cc_log.size() - cb, at + 3);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ready_cancel_busy got=%b want=0", busy); end
    // Key landing in the timeout cycle wins and restarts the idle window.
    kb = kv_log.size(); cb = cc_log.size();
    press(rand_digit(), $urandom_range(1, 20), at);
    s1 = at + 3;
    wait_to(s1 + TO_CYC - 3);
    d2 = rand_digit();
    press(d2, 2, at2);
    total++;
    if (kv_log.size() - kb !== 2 || kv_log[kb + 1].at !== s1 + TO_CYC || kv_log[kb + 1].code !== d2) begin
      bad++; $display("FAIL race_strobe count=%0d want=2 at=%0d code=%h", kv_log.size() - kb, s1 + TO_CYC, d2);
    end
    total++; if (cc_log.size() !== cb) begin bad++; $display("FAIL race_no_cancel got=%0d want=0", cc_log.size() - cb); end
    wait_to(s1 + 2 * TO_CYC + 2);
    total++;
    if (cc_log.size() - cb !== 1 || cc_log[cb] !== s1 + 2 * TO_CYC) begin
      bad++; $display("FAIL race_timeout count=%0d want=1 at=%0d", cc_log.size() - cb, s1 + 2 * TO_CYC);
    end
    // Cancel key during entry: back to idle without counting a failure.
    press(rand_digit(), $urandom_range(1, 4), at);
    kb = kv_log.size(); cb = cc_log.size();
    press(4'hD, $urandom_range(1, 4), at);
    total++;
    if (kv_log.size() - kb !== 1 || cc_log.size() - cb !== 1 || cc_log[cb] !== at + 3) begin
      bad++; $display("FAIL entry_cancel strobes=%0d cancels=%0d want=1,1 at=%0d", kv_log.size() - kb, cc_log.size() - cb, at + 3);
    end
    total++; if (busy !== 1'b0 || fail_count !== 3'd0) begin bad++; $display("FAIL entry_cancel_state busy=%b fail=%0d want=0,0", busy, fail_count); end
    // Wrong status coinciding with a cancel key: one failure, one cancel pulse.
    press(rand_digit(), $urandom_range(1, 4), at);
    kb = kv_log.size(); cb = cc_log.size();
    p = cyc;
    key_raw = 4'hD;
    step(2);
    core_wrong = 1'b1;
    step(1);
    core_wrong = 1'b0; key_raw = 4'hF;
    step(4);
    model_fail = 1;
    total++;
    if (kv_log.size() - kb !== 1 || kv_log[kb].code !== 4'hD || kv_log[kb].at !== p + 3) begin
      bad++; $display("FAIL wrong_d_strobe count=%0d want=1 at=%0d", kv_log.size() - kb, p + 3);
    end
    total++;
    if (cc_log.size() - cb !== 1 || cc_log[cb] !== p + 3) begin
      bad++; $display("FAIL wrong_d_cancel count=%0d want=1 at=%0d", cc_log.size() - cb, p + 3);
    end
    total++; if (fail_count !== 3'(model_fail)) begin bad++; $display("FAIL wrong_d_fail got=%0d want=%0d", fail_count, model_fail); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_d_busy got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_lockout();
    test_open();
    test_wrong_unlock_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_access_sequencer.md
Name: lock_access_sequencer

Overview:
- Front-end controller for the 4-digit keypad lock core; sits between the raw 4-bit keypad bus and the lock FSM.
- Converts held key codes into single-cycle key strobes and sequences entry sessions.
- Counts failed attempts, enforces a lockout window after repeated failures, and auto-cancels abandoned entries by inactivity timeout.
- Drives the core's key and cancel inputs; observes the core's unlocked/wrong status.

Parameters:
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
- LOCKOUT_CYCLES, 1000, clock cycles spent in LOCKOUT.
- TIMEOUT_CYCLES, 500, idle cycles in ENTRY before auto-cancel.
- TIMER_W, 16, timer width; both cycle counts must be < 2^TIMER_W.
- ALARM_HALF, 8, alarm half-period in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low. All flops clear immediately on assertion.
- key_raw  in  4  keypad code. 4'hF = no key, 4'hD = cancel, 4'hE = set-passcode, 4'h1..4'h9 = digits.
- core_unlocked  in  1  level from the lock core; high while open.
- core_wrong  in  1  level from the lock core; high when the entered code mismatched.
- key_valid  out  1  one-cycle strobe; key_code is valid.
- key_code  out  4  forwarded code; holds its last value between strobes.
- core_cancel  out  1  one-cycle pulse that returns the core to IDLE.
- lockout  out  1  high while in LOCKOUT.
- fail_count  out  3  consecutive failures so far.
- busy  out  1  high in ENTRY or OPEN.
- alarm  out  1  lockout alarm; tied 0 unless ALARM_EN.

Behaviour:
- Reset values:
  - key_valid=0, key_code=4'hF, core_cancel=0, lockout=0, fail_count=0, busy=0, alarm=0.
  - State=READY, timer=0, both sync stages=4'hF.
- Input path: key_raw passes through a 2-flop synchronizer. A press event is sync code != F while the previous sync code == F. A held key produces exactly one event.
- Forwarding:
  - key_valid and key_code register one cycle after the press event, so latency from a key_raw change to key_valid is 3 cycles.
  - Strobes are suppressed in LOCKOUT.
  - A cancel code (D) is forwarded as key_valid with key_code=D, and core_cancel pulses in the same cycle.
- READY:
  - Digit or E press: forward it, go to ENTRY, load timer=0.
  - D press: forward plus cancel; stay in READY.
- ENTRY:
  - Each forwarded key resets the timer; otherwise the timer increments.
  - When timer == TIMEOUT_CYCLES-1: pulse core_cancel, go to READY. Not counted as a failure.
  - core_wrong high:
    - fail_count increments, saturating at MAX_FAIL; pulse core_cancel.
    - If the new count == MAX_FAIL: go to LOCKOUT with timer=0. Otherwise go to READY.
  - core_unlocked high: fail_count=0, go to OPEN.
  - D press: forward plus cancel, go to READY; fail_count unchanged.
- OPEN:
  - All keys are forwarded, including E and the passcode-set digits. No timeout.
  - core_unlocked falling: go to READY.
  - D press: forward plus cancel; stay until core_unlocked falls.
- LOCKOUT:
  - lockout=1; all key events, including D, are discarded.
  - Timer counts to LOCKOUT_CYCLES-1, then fail_count=0, lockout=0, go to READY.
  - core_wrong and core_unlocked are ignored.
- Simultaneous events:
  - core_wrong and core_unlocked in the same cycle: wrong wins.
  - Key press in the same cycle as the timeout: the key wins, the timer reloads, and no cancel is issued.
  - core_wrong and a D press in the same cycle: the failure is counted; one core_cancel pulse only.
- Output decode:
  - busy = state in {ENTRY, OPEN}.
  - core_cancel is never high for more than 1 consecutive cycle.
- Reset mid-operation: any state returns to READY immediately; a lockout in progress is abandoned and fail_count is cleared.
- The timer saturates; it never wraps.

Optional Feature:
- Macro: LOCK_ALARM_EN.
- Defined:
  - In LOCKOUT, alarm toggles every ALARM_HALF cycles, starting at 1 on LOCKOUT entry.
  - alarm is forced to 0 in every other state and on LOCKOUT exit.
- Undefined: alarm is a constant 0 and no alarm counter is synthesized.

Test Plan (MAX_FAIL=3, LOCKOUT_CYCLES=100, TIMEOUT_CYCLES=50):
- Hold key_raw=4'h3 for 20 cycles after F -> exactly one key_valid with key_code=3, 3 cycles after the edge; state ENTRY, busy=1.
- Enter 1 digit, then idle 50 cycles -> core_cancel pulses once at cycle 50 after the last strobe; state READY; fail_count=0.
- Assert core_wrong three times across 3 sessions -> fail_count goes 1,2,3 with a core_cancel each time; lockout=1 after the third; key presses during the next 100 cycles give no key_valid; lockout=0 and fail_count=0 at cycle 100.
- Two failures, then core_unlocked=1 -> fail_count=0, OPEN; press E and 4 digits -> 5 strobes forwarded; drop core_unlocked -> READY.
- Assert core_wrong and core_unlocked together in ENTRY -> counted as a failure, no OPEN; then assert rst_n=0 mid-LOCKOUT -> all outputs reset asynchronously without a clock edge.
- With LOCK_ALARM_EN and ALARM_HALF=8 -> alarm toggles every 8 cycles during LOCKOUT; alarm is 0 in READY. Without the macro -> alarm stays 0 throughout.
